// File: rtl/tdm_demux_4ch.sv
// Receive side of a 4:1 TDM link: steers slot-ordered samples into four lanes and publishes whole frames.
// Defining TDM_DEMUX_PARITY_EN adds the din_par input and per-sample even-parity checking.
module tdm_demux_4ch #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               frame_start,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic               din_par,
`endif
    output logic [4*WIDTH-1:0] dout,
    output logic               frame_valid,
    output logic [1:0]         sel,
    output logic               frame_err,
    output logic               busy
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t             r_state;
    logic [1:0]         r_slot;
    logic [WIDTH-1:0]   r_lane0;
    logic [WIDTH-1:0]   r_lane1;
    logic [WIDTH-1:0]   r_lane2;
    logic [4*WIDTH-1:0] r_dout;
    logic               r_frame_valid;
    logic               r_frame_err;
    logic               w_frame_bad;

`ifdef TDM_DEMUX_PARITY_EN
    logic w_par_bad;
    logic r_bad;

    assign w_par_bad   = din_par ^ (^din);
    assign w_frame_bad = r_bad | w_par_bad;

    // Sticky per-frame parity flag; restarts with every frame_start and clears on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bad <= 1'b0;
        end else if (din_valid) begin
            if (frame_start) begin
                r_bad <= w_par_bad;
            end else if (r_state == COLLECT) begin
                r_bad <= (r_slot == 2'd3) ? 1'b0 : w_frame_bad;
            end
        end
    end
`else
    assign w_frame_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_slot        <= 2'd0;
            r_lane0       <= '0;
            r_lane1       <= '0;
            r_lane2       <= '0;
            r_dout        <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    IDLE: begin
                        if (frame_start) begin
                            r_lane0 <= din;
                            r_slot  <= 2'd1;
                            r_state <= COLLECT;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    COLLECT: begin
                        // A frame_start mid-frame abandons the partial frame and restarts at lane0.
                        if (frame_start) begin
                            r_frame_err <= 1'b1;
                            r_lane0     <= din;
                            r_slot      <= 2'd1;
                        end else begin
                            case (r_slot)
                                2'd1: begin
                                    r_lane1 <= din;
                                    r_slot  <= 2'd2;
                                end
                                2'd2: begin
                                    r_lane2 <= din;
                                    r_slot  <= 2'd3;
                                end
                                2'd3: begin
                                    if (w_frame_bad) begin
                                        r_frame_err <= 1'b1;
                                    end else begin
                                        r_dout        <= {din, r_lane2, r_lane1, r_lane0};
                                        r_frame_valid <= 1'b1;
                                    end
                                    r_slot  <= 2'd0;
                                    r_state <= IDLE;
                                end
                                default: begin
                                    r_lane0 <= din;
                                    r_slot  <= 2'd1;
                                end
                            endcase
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_slot  <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign dout        = r_dout;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign sel         = r_slot;
    assign busy        = (r_state == COLLECT);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch against a queue-based frame model.
// Builds with WIDTH=4 and the parity scenario when TDM_DEMUX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_tdm_demux_4ch;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int W = 4;
`else
    localparam int W = 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   din = '0;
    logic           din_valid = 1'b0;
    logic           frame_start = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    logic           din_par = 1'b0;
`endif
    logic [4*W-1:0] dout;
    logic           frame_valid;
    logic [1:0]     sel;
    logic           frame_err;
    logic           busy;

    int checks = 0;
    int errors = 0;

    // Reference model: samples of the frame being gathered, plus the expected registered outputs.
    logic [W-1:0]   q[$];
    bit             qbad;
    logic [4*W-1:0] exp_dout;
    bit             exp_fv;
    bit             exp_fe;

    tdm_demux_4ch #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
`ifdef TDM_DEMUX_PARITY_EN
        .din_par     (din_par),
`endif
        .dout        (dout),
        .frame_valid (frame_valid),
        .sel         (sel),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        qbad     = 1'b0;
        exp_dout = '0;
        exp_fv   = 1'b0;
        exp_fe   = 1'b0;
    endtask

    // Drives one cycle, advances the model across the rising edge, and returns 1ns after it.
    task automatic step(input int v, input int fs, input int d, input int bad);
        logic [W-1:0] s;
        s = W'(d);
        @(negedge clk);
        din_valid   = v[0];
        frame_start = fs[0];
        din         = s;
`ifdef TDM_DEMUX_PARITY_EN
        din_par     = (^s) ^ bad[0];
`endif
        @(posedge clk);
        exp_fv = 1'b0;
        exp_fe = 1'b0;
        if (v[0]) begin
            if (fs[0]) begin
                if (q.size() != 0) exp_fe = 1'b1;
                q.delete();
                q.push_back(s);
                qbad = bad[0];
            end else if (q.size() == 0) begin
                exp_fe = 1'b1;
            end else begin
                q.push_back(s);
                qbad = qbad | bad[0];
                if (q.size() == 4) begin
                    if (qbad) exp_fe = 1'b1;
                    else begin
                        exp_fv   = 1'b1;
                        exp_dout = {q[3], q[2], q[1], q[0]};
                    end
                    q.delete();
                    qbad = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (dout !== '0) begin errors++; $display("[TB] FAIL reset.dout got %h want 0", dout); end
        if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset.frame_valid got %b want 0", frame_valid); end
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset.frame_err got %b want 0", frame_err); end
        if (sel !== 2'd0) begin errors++; $display("[TB] FAIL reset.sel got %0d want 0", sel); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset.busy got %b want 0", busy); end
    endtask

    task automatic test_single_frame();
        int vals[4] = '{1, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            step(1, (i == 0) ? 1 : 0, vals[i], 0);
            if (i < 3) begin
                checks += 2;
                if (sel !== 2'(q.size())) begin errors++; $display("[TB] FAIL single.sel beat%0d got %0d want %0d", i, sel, q.size()); end
                if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single.busy beat%0d got %b want 1", i, busy); end
            end
        end
        checks += 5;
        if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL single.frame_valid got %b want 1", frame_valid); end
        if (dout !== exp_dout) begin errors++; $display("[TB] FAIL single.dout got %h want %h", dout, exp_dout); end
        if (sel !== 2'd0) begin errors++; $display("[TB] FAIL single.sel_end got %0d want 0", sel); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single.busy_end got %b want 0", busy); end
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL single.frame_err got %b want 0", frame_err); end
        step(0, 0, 0, 0);
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL single.pulse_width got %b want 0", frame_valid); end
    endtask

    task automatic test_stall();
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            checks += 2;
            if (sel !== 2'd2) begin errors++; $display("[TB] FAIL stall.sel gap%0d got %0d want 2", i, sel); end
            if ((frame_valid | frame_err) !== 1'b0) begin errors++; $display("[TB] FAIL stall.strobe gap%0d got fv=%b fe=%b want 0", i, frame_valid, frame_err); end
        end
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        checks += 2;
        if (frame_valid !== exp_fv) begin errors++; $display("[TB] FAIL stall.frame_valid got %b want %b", frame_valid, exp_fv); end
        if (dout !== exp_dout) begin errors++; $display("[TB] FAIL stall.dout got %h want %h", dout, exp_dout); end
    endtask

    task automatic test_back_to_back();
        int vals[8] = '{1, 0, 1, 1, 0, 1, 1, 0};
        int pulses = 0;
        int first_at = -1;
        int second_at = -1;
        for (int i = 0; i < 8; i++) begin
            step(1, (i % 4 == 0) ? 1 : 0, vals[i], 0);
            if (frame_valid === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = i; else second_at = i;
                checks++;
                if (dout !== exp_dout) begin errors++; $display("[TB] FAIL b2b.dout beat%0d got %h want %h", i, dout, exp_dout); end
            end
        end
        checks += 2;
        if (pulses != 2) begin errors++; $display("[TB] FAIL b2b.pulses got %0d want 2", pulses); end
        if (second_at - first_at != 4) begin errors++; $display("[TB] FAIL b2b.spacing got %0d want 4", second_at - first_at); end
    endtask

    task automatic test_restart();
        int pulses = 0;
        step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        step(1, 1, 0, 0);
        checks += 3;
        if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL restart.frame_err got %b want 1", frame_err); end
        if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL restart.frame_valid got %b want 0", frame_valid); end
        if (sel !== 2'd1) begin errors++; $display("[TB] FAIL restart.sel got %0d want 1", sel); end
        step(1, 0, 0, 0); if (frame_valid === 1'b1) pulses++;
        step(1, 0, 0, 0); if (frame_valid === 1'b1) pulses++;
        step(1, 0, 1, 0); if (frame_valid === 1'b1) pulses++;
        checks += 2;
        if (pulses != 1) begin errors++; $display("[TB] FAIL restart.pulses got %0d want 1", pulses); end
        if (dout !== exp_dout) begin errors++; $display("[TB] FAIL restart.dout got %h want %h", dout, exp_dout); end
    endtask

    task automatic test_orphan_and_reset();
        step(1, 0, 1, 0);
        checks += 2;
        if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL orphan.frame_err got %b want 1", frame_err); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL orphan.busy got %b want 0", busy); end
        for (int i = 0; i < 4; i++) step(1, (i == 0) ? 1 : 0, 0, 0);
        checks += 3;
        if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL orphan.frame_valid got %b want 1", frame_valid); end
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL orphan.frame_err2 got %b want 0", frame_err); end
        if (dout !== exp_dout) begin errors++; $display("[TB] FAIL orphan.dout got %h want %h", dout, exp_dout); end
        step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        checks += 3;
        if (dout !== '0) begin errors++; $display("[TB] FAIL midreset.dout got %h want 0", dout); end
        if (sel !== 2'd0) begin errors++; $display("[TB] FAIL midreset.sel got %0d want 0", sel); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset.busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1, (i == 0) ? 1 : 0, (i == 2) ? 0 : 1, 0);
        checks += 2;
        if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL postreset.frame_valid got %b want 1", frame_valid); end
        if (dout !== exp_dout) begin errors++; $display("[TB] FAIL postreset.dout got %h want %h", dout, exp_dout); end
    endtask

    task automatic test_random();
        int bad;
        for (int n = 0; n < 400; n++) begin
`ifdef TDM_DEMUX_PARITY_EN
            bad = ($urandom_range(0, 7) == 0) ? 1 : 0;
`else
            bad = 0;
`endif
            step(($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 4) == 0) ? 1 : 0, int'($urandom), bad);
            checks += 6;
            if (dout !== exp_dout) begin errors++; $display("[TB] FAIL rand.dout n=%0d got %h want %h", n, dout, exp_dout); end
            if (frame_valid !== exp_fv) begin errors++; $display("[TB] FAIL rand.frame_valid n=%0d got %b want %b", n, frame_valid, exp_fv); end
            if (frame_err !== exp_fe) begin errors++; $display("[TB] FAIL rand.frame_err n=%0d got %b want %b", n, frame_err, exp_fe); end
            if (sel !== 2'(q.size())) begin errors++; $display("[TB] FAIL rand.sel n=%0d got %0d want %0d", n, sel, q.size()); end
            if (busy !== (q.size() != 0)) begin errors++; $display("[TB] FAIL rand.busy n=%0d got %b want %b", n, busy, q.size() != 0); end
            if ((frame_valid & frame_err) !== 1'b0) begin errors++; $display("[TB] FAIL rand.exclusive n=%0d got fv=%b fe=%b", n, frame_valid, frame_err); end
        end
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        int vals[4] = '{'hA, 'h3, 'h5, 'hF};
        logic [4*W-1:0] before;
        step(0, 0, 0, 0);
        before = dout;
        for (int i = 0; i < 4; i++) step(1, (i == 0) ? 1 : 0, vals[i], (i == 2) ? 1 : 0);
        checks += 3;
        if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL parity.frame_err got %b want 1", frame_err); end
        if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL parity.frame_valid got %b want 0", frame_valid); end
        if (dout !== before) begin errors++; $display("[TB] FAIL parity.dout_held got %h want %h", dout, before); end
        for (int i = 0; i < 4; i++) step(1, (i == 0) ? 1 : 0, vals[i], 0);
        checks += 2;
        if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL parity.resend_valid got %b want 1", frame_valid); end
        if (dout !== exp_dout) begin errors++; $display("[TB] FAIL parity.resend_dout got %h want %h", dout, exp_dout); end
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_single_frame();
        test_stall();
        test_back_to_back();
        test_restart();
        test_orphan_and_reset();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        test_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux_4ch.md
Name: tdm_demux_4ch

Overview:
- Receive side of the 4:1 time-division link; the 4:1 mux drives the line, this block reassembles it.
- Accepts one sample per valid beat, steers each sample into lane 0..3 in slot order, and publishes all four lanes together as one registered frame.
- Sits between the serial link and the lane consumers; provides frame-complete strobes and framing-error flags.

Parameters:
- WIDTH, 1, bits per sample/lane.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; released synchronously by upstream.
- din  input  WIDTH  serial sample, slot-ordered lane0,lane1,lane2,lane3.
- din_valid  input  1  din carries a sample this cycle.
- frame_start  input  1  qualified by din_valid; marks the lane0 sample of a frame.
- dout  output  4*WIDTH  published frame; lane k at dout[k*WIDTH +: WIDTH].
- frame_valid  output  1  one-cycle pulse, dout updated this cycle.
- sel  output  2  slot the next accepted sample will fill.
- frame_err  output  1  one-cycle pulse on a framing violation.
- busy  output  1  high in COLLECT state.

Behaviour:
- Reset (async, rst_n=0): state IDLE, slot counter 0, staging regs 0, dout 0, frame_valid 0, frame_err 0, sel 0, busy 0.
- Accept = din_valid high at a rising edge; din_valid low stalls, with no timeout and all state held.
- IDLE:
  - Accept with frame_start=1: stage lane0, slot<=1, go COLLECT.
  - Accept with frame_start=0: sample dropped, frame_err pulses next cycle, stay IDLE.
- COLLECT:
  - Accept with frame_start=0: stage lane[slot], slot<=slot+1.
  - When the accepted sample is slot 3: on the same edge dout<={din, staged lanes 2..0}, frame_valid<=1 for one cycle, slot<=0, go IDLE.
  - Accept with frame_start=1 (any slot 1..3): frame_err pulses, partial frame discarded (dout unchanged), sample staged as lane0, slot<=1, stay COLLECT.
- Latency: dout and frame_valid are visible the cycle after the edge accepting slot 3.
- Back-to-back frames with no idle cycle: the frame_start beat immediately after slot 3 is accepted in IDLE, giving zero bubble.
- dout holds the last complete frame until the next one completes; partial frames never reach dout.
- sel equals the slot counter: 0 in IDLE, 1..3 in COLLECT. Slot counter is 2-bit and wraps 3->0 only via completion.
- busy = (state==COLLECT).
- frame_err and frame_valid never both high in the same cycle.
- rst_n asserted mid-frame: everything clears immediately, and the staged partial frame is lost.

Optional Feature:
- Macro TDM_DEMUX_PARITY_EN.
- Defined:
  - Extra input din_par (1 bit), even parity over din, valid with din_valid.
  - A parity mismatch on any accepted sample marks the frame bad.
  - At completion, a bad frame gives frame_err instead of frame_valid, and dout is unchanged.
  - A mismatch on a frame_start beat in IDLE still starts the frame, marked bad.
- Undefined:
  - No din_par port, no parity logic.
  - Behaviour otherwise identical.

Test Plan:
- Reset then WIDTH=1, beats din=1(fs),0,1,1 consecutive -> next cycle dout=4'b1101, frame_valid=1 for 1 cycle, sel=0, busy=0.
- Same frame with din_valid low 3 cycles between beat1 and beat2 -> sel holds 2 during gap, dout=4'b1101 one cycle after 4th beat, no extra strobes.
- Frame 1,0,1,1 then immediately 0(fs),1,1,0 -> two frame_valid pulses 4 cycles apart, dout 4'b1101 then 4'b0110.
- Beats 1(fs),1, then 0(fs),0,0,1 -> frame_err pulse after third beat, single frame_valid, dout=4'b1000.
- Beat without fs in IDLE (din=1) then frame 0(fs),0,0,0 -> frame_err once, dout=4'b0000, frame_valid once; rst_n low after 2 beats of a frame -> all outputs 0 immediately, next full frame publishes normally.
- TDM_DEMUX_PARITY_EN, WIDTH=4: frame 4'hA,4'h3,4'h5,4'hF with slot2 din_par wrong -> frame_err, dout unchanged; resend with correct parity -> dout=16'hF53A, frame_valid.
